// File: rtl/if_id_latch.sv
// IF/ID pipeline register with a one-entry capture buffer.
// Presents the fetched instruction and its PC to decode, holds under
// load-use and dcache stalls, squashes on taken branches/jumps, and
// parks an instruction returned by the icache during a stall so it is
// issued once the pipeline advances again.
module if_id_latch #(
  parameter int                WORD_W    = 32,
  parameter logic [WORD_W-1:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              ihit,
  input  logic [WORD_W-1:0] imemload,
  input  logic [WORD_W-1:0] pc_IF,
  input  logic              Write_IF_ID,
  input  logic              dmem_stall,
  input  logic              flush,
  output logic [WORD_W-1:0] instr_ID,
  output logic [WORD_W-1:0] pc_ID,
  output logic [WORD_W-1:0] npc_ID,
  output logic              valid_ID,
  output logic              fetch_hold
);

  // Sequential PC of an instruction; wraps at WORD_W bits, carry dropped.
  function automatic logic [WORD_W-1:0] next_pc(input logic [WORD_W-1:0] pc);
    return pc + WORD_W'(4);
  endfunction

  logic              adv;

  logic [WORD_W-1:0] instr_q, instr_d;
  logic [WORD_W-1:0] pc_q, pc_d;
  logic [WORD_W-1:0] npc_q, npc_d;
  logic              valid_q, valid_d;

  logic [WORD_W-1:0] buf_instr_q, buf_instr_d;
  logic [WORD_W-1:0] buf_pc_q, buf_pc_d;
  logic              buf_valid_q, buf_valid_d;

  // Pipeline moves only when the hazard unit allows it and the dcache is not stalling.
  assign adv = Write_IF_ID & ~dmem_stall;

  // Next-state selection: flush beats advance, buffered entry beats a fresh ihit.
  always_comb begin
    instr_d     = instr_q;
    pc_d        = pc_q;
    npc_d       = npc_q;
    valid_d     = valid_q;
    buf_instr_d = buf_instr_q;
    buf_pc_d    = buf_pc_q;
    buf_valid_d = buf_valid_q;

    if (flush) begin
      // Squash: bubble into decode, wrong-path buffered entry dropped.
      instr_d     = NOP_INSTR;
      valid_d     = 1'b0;
      buf_valid_d = 1'b0;
    end else if (adv) begin
      if (buf_valid_q) begin
        // Drain the parked instruction; fetch is held so ihit is ignored.
        instr_d     = buf_instr_q;
        pc_d        = buf_pc_q;
        npc_d       = next_pc(buf_pc_q);
        valid_d     = 1'b1;
        buf_valid_d = 1'b0;
      end else if (ihit) begin
        instr_d = imemload;
        pc_d    = pc_IF;
        npc_d   = next_pc(pc_IF);
        valid_d = 1'b1;
      end else begin
        // Nothing fetched: bubble, keep pc/npc for visibility.
        instr_d = NOP_INSTR;
        valid_d = 1'b0;
      end
    end else if (ihit && !buf_valid_q) begin
      // Stalled: park the returned instruction instead of losing it.
      buf_instr_d = imemload;
      buf_pc_d    = pc_IF;
      buf_valid_d = 1'b1;
    end
    // An ihit with the buffer already full is an upstream violation; ignored.
  end

  // State register; reset clears latch and buffer, including mid-stall.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      instr_q     <= NOP_INSTR;
      pc_q        <= '0;
      npc_q       <= '0;
      valid_q     <= 1'b0;
      buf_instr_q <= '0;
      buf_pc_q    <= '0;
      buf_valid_q <= 1'b0;
    end else begin
      instr_q     <= instr_d;
      pc_q        <= pc_d;
      npc_q       <= npc_d;
      valid_q     <= valid_d;
      buf_instr_q <= buf_instr_d;
      buf_pc_q    <= buf_pc_d;
      buf_valid_q <= buf_valid_d;
    end
  end

  assign instr_ID   = instr_q;
  assign pc_ID      = pc_q;
  assign npc_ID     = npc_q;
  assign valid_ID   = valid_q;
  assign fetch_hold = buf_valid_q;

endmodule

// File: doc/if_id_latch.md
# if_id_latch

IF/ID pipeline register for each core's five-stage pipeline. Captures the fetched instruction and its PC from the fetch stage and presents them to decode. Holds its contents under the load-use stall commanded by the hazard unit and under data-cache stalls, and squashes on taken branches and jumps. A one-entry capture buffer ensures an instruction returned by the icache during a stall is never lost.

## Interface
Parameters:
- WORD_W, 32, instruction and PC width
- NOP_INSTR, 32'h0000_0013, bubble encoding (`addi x0,x0,0`)

Ports:
- CLK  in  1  core clock; all state updates on rising edge
- nRST  in  1  reset, synchronous, active-low
- ihit  in  1  icache returns a valid instruction this cycle
- imemload  in  WORD_W  instruction data, valid when ihit=1
- pc_IF  in  WORD_W  PC of the instruction on imemload
- Write_IF_ID  in  1  from hazard unit; 0 = hold IF/ID (load-use stall)
- dmem_stall  in  1  MEM-stage dcache miss pending; freezes the pipeline
- flush  in  1  taken branch/jump resolved; squash the wrong-path instruction
- instr_ID  out  WORD_W  instruction presented to decode
- pc_ID  out  WORD_W  PC of instr_ID
- npc_ID  out  WORD_W  pc_ID + 4
- valid_ID  out  1  instr_ID is a real instruction (0 = bubble)
- fetch_hold  out  1  capture buffer occupied; fetch must hold its PC and not present a new instruction

## Operation
- Define adv = Write_IF_ID & ~dmem_stall.
- State: ID latch (instr, pc, npc, valid) and capture buffer (buf_instr, buf_pc, buf_valid).
- fetch_hold = buf_valid. This is a registered signal with no combinational path from the inputs.
- Per-cycle priority:
  1. flush=1: latch loads a bubble (instr=NOP_INSTR, valid=0, pc/npc unchanged) and buf_valid is cleared. This holds regardless of adv and ihit. An ihit in the same cycle is discarded.
  2. adv=1 with buf_valid=1: latch loads the buffer contents with valid=1, and buf_valid is cleared. The ihit input is ignored, because fetch is held.
  3. adv=1 with buf_valid=0 and ihit=1: latch loads imemload/pc_IF with valid=1.
  4. adv=1 with buf_valid=0 and ihit=0: latch loads a bubble (instr=NOP_INSTR, valid=0, pc/npc unchanged).
  5. adv=0 with ihit=1 and buf_valid=0: the latch holds, and the buffer captures imemload/pc_IF with buf_valid set to 1.
  6. adv=0 otherwise: all state holds.
- npc computation: npc = pc + 4 using WORD_W-bit wrap-around arithmetic; the carry is discarded.
- The capture buffer holds at most one entry. An ihit arriving while buf_valid=1 is a protocol violation upstream; the block ignores it and keeps the buffer unchanged.
- valid_ID=0 guarantees instr_ID=NOP_INSTR.

## Timing
- Latency: instruction with ihit at cycle N and adv=1 appears on instr_ID at cycle N+1.
- Buffered path: ihit at N with adv=0 sets fetch_hold at N+1. The first cycle M>N with adv=1 presents the buffered instruction at M+1, and fetch_hold drops at M+1.
- Flush: effective on the next edge. Outputs at N+1 are a bubble and fetch_hold=0.
- Reset (nRST=0 at an edge), including mid-stall or with the buffer full, sets:
  - instr_ID=NOP_INSTR, pc_ID=0, npc_ID=0 (not recomputed from pc_ID on reset)
  - valid_ID=0, fetch_hold=0, buffer contents cleared to 0
- Outputs are registered only; there are no input-to-output combinational paths.

## Test plan
- Reset: hold nRST=0 for 2 cycles with ihit=1 → instr_ID=0x00000013, valid_ID=0, pc_ID=0, npc_ID=0, fetch_hold=0.
- Normal flow: ihit=1, imemload=0x00500093, pc_IF=0x100, adv=1 → next cycle instr_ID=0x00500093, pc_ID=0x100, npc_ID=0x104, valid_ID=1.
- Load-use capture and drain:
  - Cycle N: Write_IF_ID=0, ihit=1, imemload=0x002081B3, pc_IF=0x104 → ID latch unchanged, and fetch_hold=1 at N+1.
  - Cycle N+1: Write_IF_ID=1 → at N+2, instr_ID=0x002081B3, pc_ID=0x104, fetch_hold=0.
- Flush with full buffer: buffer holds pc 0x108; assert flush=1 with Write_IF_ID=0 → next cycle valid_ID=0, instr_ID=0x00000013, fetch_hold=0. The buffered instruction is never issued.
- dmem_stall: hold dmem_stall=1 for 5 cycles with Write_IF_ID=1 and a single ihit → latch unchanged and the buffer captures that ihit. Release dmem_stall → the buffered instruction appears one cycle later.
- PC wrap: ihit with pc_IF=0xFFFFFFFC, adv=1 → pc_ID=0xFFFFFFFC, npc_ID=0x00000000.
